data_block_sequencer: RTL

Control stage driving the 32-bit structural counter in the SD host DATA path. It converts a transfer request (block size, block count) into the counter's enable/mode/preload controls and consumes the counter's RCO to detect the end of each data block. Between blocks it times the CRC16 + end-bit window. It reports per-block and per-transfer completion to the DATA controller.

---
 rtl/data_pkg.sv | 23 ++
 rtl/data_gap_timer.sv | 36 +++
 rtl/data_block_sequencer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/data_pkg.sv
// Shared definitions for the SD host DATA path block sequencer: counter mode
// codes, sequencer state encoding and the default CRC16 + end-bit gap length.
package data_pkg;

  // Control codes understood by the 32-bit structural counter
  localparam logic [1:0] MODO_HOLD = 2'b00;
  localparam logic [1:0] MODO_DOWN = 2'b01;
  localparam logic [1:0] MODO_LOAD = 2'b11;

  // 16 CRC bits plus the end bit follow every data block
  localparam int GAP_CYCLES_DEF = 17;

  // Width of the gap timer; wide enough for any gap up to 32 cycles
  localparam int GAP_TIMER_W = 5;

  typedef enum logic [1:0] {
    STATE_IDLE = 2'd0,
    STATE_LOAD = 2'd1,
    STATE_RUN  = 2'd2,
    STATE_GAP  = 2'd3
  } seqStateT;

endpackage

// File: rtl/data_gap_timer.sv
// Small cycle timer for the idle window between data blocks. Clear forces the
// count back to zero, enable advances it, and done marks the final cycle of
// the window so the sequencer can close the block on that cycle.
module data_gap_timer
  import data_pkg::*;
#(
  parameter int TERMINAL = GAP_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam logic [GAP_TIMER_W-1:0] LAST_COUNT = GAP_TIMER_W'(TERMINAL - 1);

  logic [GAP_TIMER_W-1:0] count;

  // Counts gap cycles; clear wins over enable so each window starts from zero
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + GAP_TIMER_W'(1);
    end
  end

  // Terminal count only means something while the window is being timed
  always_comb begin
    done = enable && (count == LAST_COUNT);
  end

endmodule

// File: rtl/data_block_sequencer.sv
// Control stage in front of the DATA path down-counter. Turns a transfer
// request (block size, block count) into counter load/count/hold controls,
// watches the counter RCO for the last byte of each block, times the CRC16 +
// end-bit window after every block and reports block/transfer completion.
module data_block_sequencer
  import data_pkg::*;
#(
  parameter int BSIZE_W    = 12,
  parameter int BCNT_W     = 16,
  parameter int CNT_W      = 32,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
  input  logic               iCLK,
  input  logic               iReset,
  input  logic               iStart,
  input  logic [BSIZE_W-1:0] iBlockSize,
  input  logic [BCNT_W-1:0]  iBlockCount,
  input  logic               iByteValid,
  input  logic               iAbort,
  input  logic               iRCO,
  output logic               oENB,
  output logic [1:0]         oMODO,
  output logic [CNT_W-1:0]   oD,
  output logic               oBusy,
  output logic               oBlockDone,
  output logic               oXferDone,
  output logic               oAbortAck
);

  seqStateT            state;
  seqStateT            nextState;
  logic [BCNT_W-1:0]   remaining;
  logic [CNT_W-1:0]    preload;
  logic                abortAck;
  logic                startAccept;
  logic                abortTaken;
  logic                lastBlock;
  logic                gapClear;
  logic                gapEnable;
  logic                gapDone;

  // A request is only taken in IDLE and only when it describes real data
  assign startAccept = (state == STATE_IDLE) && iStart &&
                       (iBlockSize != '0) && (iBlockCount != '0);
  assign abortTaken  = (state != STATE_IDLE) && iAbort;
  assign lastBlock   = (remaining == BCNT_W'(1));
  assign gapEnable   = (state == STATE_GAP);
  assign gapClear    = (state != STATE_GAP);

  data_gap_timer #(
    .TERMINAL (GAP_CYCLES)
  ) gapTimer (
    .clock  (iCLK),
    .reset  (iReset),
    .clear  (gapClear),
    .enable (gapEnable),
    .done   (gapDone)
  );

  // State register
  always_ff @(posedge iCLK or posedge iReset) begin
    if (iReset) begin
      state <= STATE_IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic; abort overrides every other transition outside IDLE
  always_comb begin
    nextState = state;
    unique case (state)
      STATE_IDLE: begin
        if (startAccept) begin
          nextState = STATE_LOAD;
        end
      end
      STATE_LOAD: begin
        if (iAbort) begin
          nextState = STATE_IDLE;
        end else begin
          nextState = STATE_RUN;
        end
      end
      STATE_RUN: begin
        if (iAbort) begin
          nextState = STATE_IDLE;
        end else if (iByteValid && iRCO) begin
          nextState = STATE_GAP;
        end
      end
      STATE_GAP: begin
        if (iAbort) begin
          nextState = STATE_IDLE;
        end else if (gapDone) begin
          nextState = lastBlock ? STATE_IDLE : STATE_LOAD;
        end
      end
      default: nextState = STATE_IDLE;
    endcase
  end

  // Output decode from registered state; only oENB follows iByteValid in RUN
  always_comb begin
    oENB       = 1'b0;
    oMODO      = MODO_HOLD;
    oBusy      = 1'b0;
    oBlockDone = 1'b0;
    oXferDone  = 1'b0;
    unique case (state)
      STATE_IDLE: begin
        oENB = 1'b0;
      end
      STATE_LOAD: begin
        oENB  = 1'b1;
        oMODO = MODO_LOAD;
        oBusy = 1'b1;
      end
      STATE_RUN: begin
        oENB  = iByteValid;
        oMODO = MODO_DOWN;
        oBusy = 1'b1;
      end
      STATE_GAP: begin
        oBusy      = 1'b1;
        oBlockDone = gapDone;
        oXferDone  = gapDone && lastBlock;
      end
      default: begin
        oENB = 1'b0;
      end
    endcase
    oD        = preload;
    oAbortAck = abortAck;
  end

  // Request latches: preload is size-1 so RCO fires on the block's last byte
  always_ff @(posedge iCLK or posedge iReset) begin
    if (iReset) begin
      preload   <= '0;
      remaining <= '0;
    end else if (startAccept) begin
      preload   <= CNT_W'(iBlockSize - BSIZE_W'(1));
      remaining <= iBlockCount;
    end else if ((state == STATE_GAP) && gapDone && !iAbort) begin
      remaining <= remaining - BCNT_W'(1);
    end
  end

  // Abort acknowledge is a registered pulse in the first IDLE cycle
  always_ff @(posedge iCLK or posedge iReset) begin
    if (iReset) begin
      abortAck <= 1'b0;
    end else begin
      abortAck <= abortTaken;
    end
  end

endmodule
